// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer.
package irq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ENTER = 2'd2,
        ISR   = 2'd3
    } irq_state_e;

    // Source indices as wired on the core
    localparam int unsigned SRC_PPU = 0;
    localparam int unsigned SRC_ACC = 1;
    localparam int unsigned SRC_ETH = 2;
    localparam int unsigned SRC_TMR = 3;

    // Width of a source index, never less than one bit
    function automatic int unsigned idx_width(input int unsigned num_src);
        return (num_src <= 1) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_SRC-1:0] onehot
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        any    = 1'b0;
        index  = '0;
        onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any    = 1'b1;
                index  = IDX_W'(i);
                onehot = NUM_SRC'(1) << i;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt controller: latches edges, masks, and sequences pipeline
// flush / redirect on entry and the return redirect on rti.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               rsi_ex,
    input  logic [XLEN-1:0]    rsi_data,
    input  logic               rti_ex,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic               pipe_stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [XLEN-1:0]    cause_data
);

    localparam int unsigned IDX_W = idx_width(NUM_SRC);
    localparam int unsigned CNT_W = (DRAIN_CYCLES <= 1) ? 1 : $clog2(DRAIN_CYCLES);

    irq_state_e         state_q;
    irq_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               take;
    logic               rti_ret;

    logic [NUM_SRC-1:0] src_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [XLEN-1:0]    handler_q;
    logic               handler_valid_q;
    logic [XLEN-1:0]    epc_q;
    logic [IDX_W-1:0]   cause_q;

    logic               flush_q;
    logic               redirect_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic               in_isr_q;
    logic [NUM_SRC-1:0] ack_q;

    logic [NUM_SRC-1:0] src_rise;
    logic [NUM_SRC-1:0] req;
    logic               enc_any;
    logic [IDX_W-1:0]   enc_index;
    logic [NUM_SRC-1:0] enc_onehot;

    assign src_rise = irq_src & ~src_prev_q;
    assign req      = pending_q & mask_q;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req    (req),
        .any    (enc_any),
        .index  (enc_index),
        .onehot (enc_onehot)
    );

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, take decision and rti return strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        rti_ret = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_any && handler_valid_q && !pipe_stall && !rti_ex) begin
                    take    = 1'b1;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!pipe_stall) begin
                    if (cnt_q == '0) begin
                        state_d = ENTER;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ENTER: begin
                state_d = ISR;
            end
            ISR: begin
                if (rti_ex) begin
                    rti_ret = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Edge capture, pending/mask, handler, return PC and cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q      <= '0;
            pending_q       <= '0;
            mask_q          <= '0;
            handler_q       <= '0;
            handler_valid_q <= 1'b0;
            epc_q           <= '0;
            cause_q         <= '0;
        end else begin
            src_prev_q <= irq_src;
            // A fresh edge on the source being acknowledged re-arms it
            pending_q  <= (pending_q & ~(take ? enc_onehot : '0)) | src_rise;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
            // An rsi caught in the flush window is being squashed
            if (rsi_ex && (state_q != FLUSH)) begin
                handler_q       <= rsi_data;
                handler_valid_q <= 1'b1;
            end
            if (take) begin
                epc_q   <= commit_pc;
                cause_q <= enc_index;
            end
        end
    end

    // Registered pipeline-control outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            in_isr_q      <= 1'b0;
            ack_q         <= '0;
        end else begin
            flush_q       <= (state_d == FLUSH) || (state_d == ENTER);
            redirect_q    <= (state_d == ENTER);
            redirect_pc_q <= (state_d == ENTER) ? handler_q : '0;
            in_isr_q      <= (state_d == ISR);
            ack_q         <= take ? enc_onehot : '0;
        end
    end

    // Return redirect bypasses the output register so fetch turns the same cycle
    assign flush          = flush_q;
    assign redirect_valid = redirect_q | rti_ret;
    assign redirect_pc    = rti_ret ? epc_q : redirect_pc_q;
    assign in_isr         = in_isr_q;
    assign irq_ack        = ack_q;
    assign cause_data     = XLEN'(cause_q);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer.
module tb_irq_sequencer;
    import irq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_src;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic        rsi_ex;
    logic [31:0] rsi_data;
    logic        rti_ex;
    logic [31:0] commit_pc;
    logic        pipe_stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_isr;
    logic [3:0]  irq_ack;
    logic [31:0] cause_data;

    int total = 0;
    int bad   = 0;

    irq_sequencer #(
        .NUM_SRC      (4),
        .XLEN         (32),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src        (irq_src),
        .mask_wr        (mask_wr),
        .mask_data      (mask_data),
        .rsi_ex         (rsi_ex),
        .rsi_data       (rsi_data),
        .rti_ex         (rti_ex),
        .commit_pc      (commit_pc),
        .pipe_stall     (pipe_stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .in_isr         (in_isr),
        .irq_ack        (irq_ack),
        .cause_data     (cause_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_wr = 1'b1; mask_data = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic write_handler(input logic [31:0] h);
        rsi_ex = 1'b1; rsi_data = h;
        tick();
        rsi_ex = 1'b0;
    endtask

    task automatic do_rti();
        rti_ex = 1'b1;
        tick();
        rti_ex = 1'b0;
    endtask

    // Walk from the first FLUSH cycle into ISR, tallying flush/redirect cycles
    task automatic run_to_isr(output int fl, output int rv, output logic [31:0] rpc, output bit ok);
        fl = 0; rv = 0; rpc = '0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_isr) begin
                ok = 1'b1;
                break;
            end
            if (flush) fl++;
            if (redirect_valid) begin
                rv++;
                rpc = redirect_pc;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        irq_src = '0; mask_wr = 1'b0; mask_data = '0; rsi_ex = 1'b0; rsi_data = '0;
        rti_ex = 1'b0; commit_pc = '0; pipe_stall = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({flush, redirect_valid, in_isr} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {flush, redirect_valid, in_isr});
        end
        total++;
        if (irq_ack !== 4'b0000 || redirect_pc !== 32'h0 || cause_data !== 32'h0) begin
            bad++; $display("FAIL reset_data got ack=%b pc=%h cause=%h want all 0", irq_ack, redirect_pc, cause_data);
        end
    endtask

    task automatic test_no_handler();
        int fl; int rv; logic [31:0] rpc; bit ok; int seen;
        write_mask(4'b0001);
        irq_src[SRC_PPU] = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (flush || irq_ack != 4'b0000) seen++;
        end
        irq_src[SRC_PPU] = 1'b0;
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL nohandler_idle got=%0d flush/ack cycles want=0", seen);
        end
        write_handler(32'h800);
        total++;
        if (flush !== 1'b0) begin
            bad++; $display("FAIL nohandler_decide got flush=%b want=0", flush);
        end
        tick();
        total++;
        if (flush !== 1'b1 || irq_ack !== 4'b0001) begin
            bad++; $display("FAIL nohandler_take got flush=%b ack=%b want 1/0001", flush, irq_ack);
        end
        run_to_isr(fl, rv, rpc, ok);
        total++;
        if (!ok || rv !== 1 || rpc !== 32'h800) begin
            bad++; $display("FAIL nohandler_entry got ok=%0d rv=%0d pc=%h want 1/1/800", ok, rv, rpc);
        end
        do_rti();
    endtask

    task automatic test_basic();
        int fl; int rv; logic [31:0] rpc; bit ok;
        write_handler(32'h400);
        write_mask(4'b0001);
        commit_pc = 32'h120;
        irq_src[SRC_PPU] = 1'b1;
        tick();
        irq_src[SRC_PPU] = 1'b0;
        tick();
        commit_pc = 32'h200;
        total++;
        if (irq_ack !== 4'b0001 || cause_data !== 32'd0) begin
            bad++; $display("FAIL basic_ack got ack=%b cause=%0d want 0001/0", irq_ack, cause_data);
        end
        run_to_isr(fl, rv, rpc, ok);
        total++;
        if (!ok || fl !== 4) begin
            bad++; $display("FAIL basic_flush_len got ok=%0d flush=%0d want 1/4", ok, fl);
        end
        total++;
        if (rv !== 1 || rpc !== 32'h400) begin
            bad++; $display("FAIL basic_redirect got rv=%0d pc=%h want 1/400", rv, rpc);
        end
        total++;
        if (in_isr !== 1'b1 || flush !== 1'b0 || irq_ack !== 4'b0000) begin
            bad++; $display("FAIL basic_isr got isr=%b flush=%b ack=%b want 1/0/0000", in_isr, flush, irq_ack);
        end
        rti_ex = 1'b1;
        #1;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
            bad++; $display("FAIL basic_rti_redirect got v=%b pc=%h want 1/120", redirect_valid, redirect_pc);
        end
        tick();
        rti_ex = 1'b0;
        total++;
        if (in_isr !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL basic_rti_exit got isr=%b v=%b want 0/0", in_isr, redirect_valid);
        end
    endtask

    task automatic test_priority();
        int fl; int rv; logic [31:0] rpc; bit ok;
        write_mask(4'b1111);
        irq_src[SRC_ETH] = 1'b1;
        irq_src[SRC_ACC] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        total++;
        if (irq_ack !== 4'b0010 || cause_data !== 32'd1) begin
            bad++; $display("FAIL prio_first got ack=%b cause=%0d want 0010/1", irq_ack, cause_data);
        end
        run_to_isr(fl, rv, rpc, ok);
        do_rti();
        total++;
        if (flush !== 1'b0 || in_isr !== 1'b0) begin
            bad++; $display("FAIL prio_gap got flush=%b isr=%b want 0/0", flush, in_isr);
        end
        tick();
        total++;
        if (irq_ack !== 4'b0100 || cause_data !== 32'd2 || flush !== 1'b1) begin
            bad++; $display("FAIL prio_second got ack=%b cause=%0d flush=%b want 0100/2/1", irq_ack, cause_data, flush);
        end
        run_to_isr(fl, rv, rpc, ok);
        total++;
        if (!ok || rpc !== 32'h400) begin
            bad++; $display("FAIL prio_second_entry got ok=%0d pc=%h want 1/400", ok, rpc);
        end
        do_rti();
    endtask

    task automatic test_masking();
        int fl; int rv; logic [31:0] rpc; bit ok; int seen;
        write_mask(4'b0000);
        irq_src[SRC_TMR] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (flush || irq_ack != 4'b0000) seen++;
        end
        irq_src[SRC_TMR] = 1'b0;
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL mask_hold got=%0d flush/ack cycles want=0", seen);
        end
        write_mask(4'b1000);
        total++;
        if (flush !== 1'b0) begin
            bad++; $display("FAIL mask_decide got flush=%b want=0", flush);
        end
        tick();
        total++;
        if (flush !== 1'b1 || irq_ack !== 4'b1000 || cause_data !== 32'd3) begin
            bad++; $display("FAIL mask_take got flush=%b ack=%b cause=%0d want 1/1000/3", flush, irq_ack, cause_data);
        end
        run_to_isr(fl, rv, rpc, ok);
        do_rti();
    endtask

    task automatic test_stall_flush();
        int fl; int rv; logic [31:0] rpc; bit ok; int pre;
        write_mask(4'b0001);
        irq_src[SRC_PPU] = 1'b1;
        tick();
        irq_src[SRC_PPU] = 1'b0;
        tick();
        pre = 0;
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (flush) pre++;
            if (redirect_valid) pre += 100;
            tick();
        end
        pipe_stall = 1'b0;
        run_to_isr(fl, rv, rpc, ok);
        total++;
        if (!ok || (pre + fl) !== 7) begin
            bad++; $display("FAIL stall_flush_len got ok=%0d flush=%0d want 1/7", ok, pre + fl);
        end
        total++;
        if (rv !== 1 || rpc !== 32'h400) begin
            bad++; $display("FAIL stall_redirect got rv=%0d pc=%h want 1/400", rv, rpc);
        end
        do_rti();
    endtask

    task automatic test_reset_flush();
        int seen;
        write_mask(4'b0001);
        irq_src[SRC_PPU] = 1'b1;
        irq_src[SRC_ACC] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        total++;
        if (flush !== 1'b1) begin
            bad++; $display("FAIL rstflush_pre got flush=%b want=1", flush);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({flush, redirect_valid, in_isr} !== 3'b000 || irq_ack !== 4'b0000) begin
            bad++; $display("FAIL rstflush_async got ctrl=%b ack=%b want 000/0000",
                            {flush, redirect_valid, in_isr}, irq_ack);
        end
        tick();
        rst_n = 1'b1;
        write_handler(32'h400);
        write_mask(4'b0011);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (flush || irq_ack != 4'b0000) seen++;
            tick();
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rstflush_pending got=%0d flush/ack cycles want=0", seen);
        end
        irq_src[SRC_ACC] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        total++;
        if (flush !== 1'b1 || irq_ack !== 4'b0010) begin
            bad++; $display("FAIL rstflush_recover got flush=%b ack=%b want 1/0010", flush, irq_ack);
        end
    endtask

    initial begin
        test_reset();
        test_no_handler();
        test_basic();
        test_priority();
        test_masking();
        test_stall_flush();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
